mult_rr_scheduler: RTL and testbench

- Shares one 8x8 unsigned combinational multiplier (the team's wallace_multiplier) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on every requester port and on the result port.
- Operand and result registers form a 2-stage pipeline, giving full throughput of one product per cycle.
- Sits between DSP-style clients and the shared multiplier; the result is tagged with the ID of the requester that issued it.

---
 rtl/mult_rr_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_mult_rr_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mult_rr_scheduler
//
// Shares one 8x8 unsigned multiplier between NUM_REQ requesters. A round-robin
// arbiter picks one requester per cycle, its operands are captured in stage S1,
// the product is formed combinationally and captured in the output stage S2.
// Both stages use valid/ready handshakes, so a product can be accepted and one
// retired on every cycle. Each result carries the index of its requester.
//
// Optional feature: define MULT_RR_PERF_EN to add the op_count output, a
// saturating count of completed result handshakes.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   [NUM_REQ]    per-requester operand valid
//   req_ready    out  [NUM_REQ]    per-requester accept (at most one bit high)
//   req_a        in   [8*NUM_REQ]  multiplicands, requester i at [8i+7:8i]
//   req_b        in   [8*NUM_REQ]  multipliers, packed like req_a
//   flush        in   synchronous clear of both pipeline stages
//   res_valid    out  result valid
//   res_ready    in   downstream accept
//   res_product  out  [16]         unsigned a*b
//   res_id       out  [ID_W]       requester index of the result
//   op_count     out  [16]         completed operations (MULT_RR_PERF_EN only)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// carry_save_adder
//
// Word-level 3:2 compressor: x + y + z == sum + carry (mod 2**W).
// Ports: x, y, z in [W]; sum, carry out [W].
// -----------------------------------------------------------------------------
module carry_save_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    assign sum   = x ^ y ^ z;
    assign maj   = (x & y) | (x & z) | (y & z);
    // The majority bit carries into the next column; the top carry falls off,
    // which is harmless because the full product always fits in W bits.
    assign carry = {maj[W-2:0], 1'b0};

endmodule

// -----------------------------------------------------------------------------
// wallace_multiplier
//
// Unsigned 8x8 -> 16 combinational multiplier. Eight partial-product rows are
// reduced with carry-save adders (8 -> 6 -> 4 -> 3 -> 2 rows) and the last two
// rows are summed with a single carry-propagate add.
// Ports: a, b in [8]; product out [16].
// -----------------------------------------------------------------------------
module wallace_multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product
);

    logic [15:0] pp [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pp
            assign pp[gi] = b[gi] ? ({8'd0, a} << gi) : 16'd0;
        end
    endgenerate

    // Level 1: 8 rows -> 6 rows
    logic [15:0] l1_s0, l1_c0, l1_s1, l1_c1;
    carry_save_adder #(.W(16)) u_l1_0 (.x(pp[0]), .y(pp[1]), .z(pp[2]), .sum(l1_s0), .carry(l1_c0));
    carry_save_adder #(.W(16)) u_l1_1 (.x(pp[3]), .y(pp[4]), .z(pp[5]), .sum(l1_s1), .carry(l1_c1));

    // Level 2: 6 rows -> 4 rows
    logic [15:0] l2_s0, l2_c0, l2_s1, l2_c1;
    carry_save_adder #(.W(16)) u_l2_0 (.x(l1_s0), .y(l1_c0), .z(l1_s1), .sum(l2_s0), .carry(l2_c0));
    carry_save_adder #(.W(16)) u_l2_1 (.x(l1_c1), .y(pp[6]), .z(pp[7]), .sum(l2_s1), .carry(l2_c1));

    // Level 3: 4 rows -> 3 rows
    logic [15:0] l3_s, l3_c;
    carry_save_adder #(.W(16)) u_l3 (.x(l2_s0), .y(l2_c0), .z(l2_s1), .sum(l3_s), .carry(l3_c));

    // Level 4: 3 rows -> 2 rows
    logic [15:0] l4_s, l4_c;
    carry_save_adder #(.W(16)) u_l4 (.x(l3_s), .y(l3_c), .z(l2_c1), .sum(l4_s), .carry(l4_c));

    assign product = l4_s + l4_c;

endmodule

// -----------------------------------------------------------------------------
// mult_rr_scheduler (top)
// -----------------------------------------------------------------------------
module mult_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    input  logic                   flush,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [15:0]            res_product,
    output logic [ID_W-1:0]        res_id
`ifdef MULT_RR_PERF_EN
    ,
    output logic [15:0]            op_count
`endif
);

    localparam int PAD_W = 2 ** ID_W;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic              s1_valid_reg;
    logic [7:0]        s1_a_reg;
    logic [7:0]        s1_b_reg;
    logic [ID_W-1:0]   s1_id_reg;
    logic              res_valid_reg;
    logic [15:0]       res_product_reg;
    logic [ID_W-1:0]   res_id_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   rr_ptr_next;

    // ---------------------------------------------------------------------
    // Ready chain: a stage can accept when it is empty or is being drained
    // ---------------------------------------------------------------------
    logic s2_ready;
    logic s1_ready;

    assign s2_ready = !res_valid_reg || res_ready;
    assign s1_ready = !s1_valid_reg || s2_ready;

    // ---------------------------------------------------------------------
    // Round-robin arbitration
    // scan_idx[k] is the requester examined k-th, starting at rr_ptr.
    // ---------------------------------------------------------------------
    logic [ID_W:0]     scan_sum  [NUM_REQ];
    logic [ID_W-1:0]   scan_idx  [NUM_REQ];
    logic [NUM_REQ-1:0] rot_valid;
    logic [PAD_W-1:0]  valid_pad;
    logic [7:0]        a_arr     [NUM_REQ];
    logic [7:0]        b_arr     [NUM_REQ];

    // Zero-extend so a ID_W-bit index never reaches past the vector
    assign valid_pad = PAD_W'(req_valid);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_scan
            // rr_ptr < NUM_REQ and gi < NUM_REQ, so one conditional subtract
            // is enough to wrap modulo NUM_REQ.
            assign scan_sum[gi] = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
            assign scan_idx[gi] = (scan_sum[gi] >= (ID_W+1)'(NUM_REQ))
                                ? ID_W'(scan_sum[gi] - (ID_W+1)'(NUM_REQ))
                                : scan_sum[gi][ID_W-1:0];
            assign rot_valid[gi] = valid_pad[scan_idx[gi]];

            assign a_arr[gi] = req_a[8*gi +: 8];
            assign b_arr[gi] = req_b[8*gi +: 8];
        end
    endgenerate

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;

    // Walk from the far end so the earliest valid position in scan order wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[k];
            end
        end
    end

    // A transfer needs a valid winner, room in S1, no flush and no reset.
    // Gating with rst_n keeps every ready low while reset is held.
    logic transfer;
    assign transfer = grant_found && s1_ready && !flush && rst_n;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = transfer && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Operand select for the winner
    logic [7:0] sel_a;
    logic [7:0] sel_b;

    always_comb begin
        sel_a = 8'd0;
        sel_b = 8'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = a_arr[i];
                sel_b = b_arr[i];
            end
        end
    end

    always_comb begin
        if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = grant_idx + ID_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Stage S1: operand register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= 8'd0;
            s1_b_reg     <= 8'd0;
            s1_id_reg    <= '0;
            rr_ptr_reg   <= '0;
        end else if (flush) begin
            // Pointer survives a flush so fairness is not disturbed
            s1_valid_reg <= 1'b0;
        end else if (transfer) begin
            s1_valid_reg <= 1'b1;
            s1_a_reg     <= sel_a;
            s1_b_reg     <= sel_b;
            s1_id_reg    <= grant_idx;
            rr_ptr_reg   <= rr_ptr_next;
        end else if (s1_ready) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Shared multiplier between S1 and S2
    // ---------------------------------------------------------------------
    logic [15:0] mult_product;

    wallace_multiplier u_mult (
        .a       (s1_a_reg),
        .b       (s1_b_reg),
        .product (mult_product)
    );

    // ---------------------------------------------------------------------
    // Stage S2: output register; held stable while stalled
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg   <= 1'b0;
            res_product_reg <= 16'd0;
            res_id_reg      <= '0;
        end else if (flush) begin
            res_valid_reg <= 1'b0;
        end else if (s2_ready) begin
            if (s1_valid_reg) begin
                res_valid_reg   <= 1'b1;
                res_product_reg <= mult_product;
                res_id_reg      <= s1_id_reg;
            end else begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign res_valid   = res_valid_reg;
    assign res_product = res_product_reg;
    assign res_id      = res_id_reg;

`ifdef MULT_RR_PERF_EN
    // ---------------------------------------------------------------------
    // Completed-operation counter; saturates, only reset clears it
    // ---------------------------------------------------------------------
    logic [15:0] op_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_reg <= 16'd0;
        end else if (res_valid_reg && res_ready && (op_count_reg != 16'hFFFF)) begin
            op_count_reg <= op_count_reg + 16'd1;
        end
    end

    assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_mult_rr_scheduler.sv
`timescale 1ns/1ps
module tb_mult_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic                 flush;
    logic                 res_valid;
    logic                 res_ready;
    logic [15:0]          res_product;
    logic [ID_W-1:0]      res_id;
`ifdef MULT_RR_PERF_EN
    logic [15:0]          op_count;
`endif

    always #5 clk = ~clk;

    mult_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .flush       (flush),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_product (res_product),
        .res_id      (res_id)
`ifdef MULT_RR_PERF_EN
        ,
        .op_count    (op_count)
`endif
    );

    typedef struct packed {
        logic [15:0]     p;
        logic [ID_W-1:0] id;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          mptr = 0;        // reference round-robin pointer
    int          last_grant = -1;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    bit          auto_new = 1'b0; // give a granted requester fresh operands
    bit          hold_chk = 1'b0;
    logic [15:0] hold_p;
    logic [ID_W-1:0] hold_id;

    // One clock cycle: called just after a rising edge with inputs set.
    task automatic step();
        int   exp_g;
        int   g;
        exp_t e;
        #1;
        exp_g = -1;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_valid[(mptr + k) % NUM_REQ]) exp_g = (mptr + k) % NUM_REQ;
        g = -1;
        last_grant = -1;
        if (hold_chk) begin
            tests++;
            if (res_valid !== 1'b1 || res_product !== hold_p || res_id !== hold_id) begin
                fails++;
                $display("FAIL hold_stable: got v=%0b p=%h id=%0d, need v=1 p=%h id=%0d",
                         res_valid, res_product, res_id, hold_p, hold_id);
            end
        end
        if (req_ready !== '0) begin
            tests++;
            if (exp_g < 0 || req_ready !== (4'b0001 << exp_g)) begin
                fails++;
                $display("FAIL grant_pick: got req_ready=%b, need winner %0d (valid=%b)",
                         req_ready, exp_g, req_valid);
            end
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i] === 1'b1) g = i;
            if (g >= 0 && req_valid[g]) begin
                e.p  = {8'd0, req_a[8*g +: 8]} * {8'd0, req_b[8*g +: 8]};
                e.id = ID_W'(g);
                sb.push_back(e);
                mptr = (g + 1) % NUM_REQ;
                last_grant = g;
                acc_cnt++;
            end
        end
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            tests++;
            pop_cnt++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got p=%h id=%0d, need no result", res_product, res_id);
            end else begin
                e = sb.pop_front();
                if (res_product !== e.p || res_id !== e.id) begin
                    fails++;
                    $display("FAIL result_data: got p=%h id=%0d, need p=%h id=%0d",
                             res_product, res_id, e.p, e.id);
                end
            end
        end
        hold_chk = (res_valid === 1'b1 && res_ready === 1'b0 && flush === 1'b0);
        hold_p   = res_product;
        hold_id  = res_id;
        @(posedge clk);
        if (flush) sb.delete();
        #1;
        if (auto_new && g >= 0) begin
            req_a[8*g +: 8] = 8'($urandom);
            req_b[8*g +: 8] = 8'($urandom);
        end
    endtask

    task automatic drain();
        req_valid = '0;
        res_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d results outstanding, need 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        req_a = $urandom;
        req_b = $urandom;
        flush = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (req_ready !== '0) begin fails++; $display("FAIL reset_ready: got %b, need 0000", req_ready); end
        tests++;
        if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, need 0", res_valid); end
        tests++;
        if (res_product !== 16'd0) begin fails++; $display("FAIL reset_product: got %h, need 0000", res_product); end
        tests++;
        if (res_id !== '0) begin fails++; $display("FAIL reset_id: got %0d, need 0", res_id); end
`ifdef MULT_RR_PERF_EN
        tests++;
        if (op_count !== 16'd0) begin fails++; $display("FAIL reset_op_count: got %0d, need 0", op_count); end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '0;
        mptr = 0;
        sb.delete();
        hold_chk = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_fairness();
        req_valid = '1;
        res_ready = 1'b1;
        auto_new  = 1'b1;
        pop_cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (last_grant !== i % NUM_REQ) begin
                fails++;
                $display("FAIL fair_order: cycle %0d got grant %0d, need %0d", i, last_grant, i % NUM_REQ);
            end
        end
        tests++;
        if (pop_cnt !== 4) begin
            fails++;
            $display("FAIL fair_throughput: got %0d results in 6 cycles, need 4", pop_cnt);
        end
        auto_new = 1'b0;
        drain();
        $display("[TB] fairness rotation checked");
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_a[23:16] = 8'd13;
        req_b[23:16] = 8'd11;
        res_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_grant: got %b, need 0100", req_ready); end
        step();
        req_valid = '0;
        #1;
        tests++;
        if (res_valid !== 1'b0) begin fails++; $display("FAIL single_latency_early: got v=%b, need 0", res_valid); end
        step();
        #1;
        tests++;
        if (res_valid !== 1'b1 || res_product !== 16'd143 || res_id !== 2'd2) begin
            fails++;
            $display("FAIL single_result: got v=%b p=%0d id=%0d, need v=1 p=143 id=2",
                     res_valid, res_product, res_id);
        end
        step();
        drain();
        $display("[TB] single op 13*11 checked");
    endtask

    task automatic test_max();
        req_valid = 4'b0001;
        req_a[7:0] = 8'hFF;
        req_b[7:0] = 8'hFF;
        res_ready = 1'b1;
        step();
        req_valid = 4'b0010;
        req_a[15:8] = 8'h00;
        req_b[15:8] = 8'hA5;
        step();
        req_valid = '0;
        #1;
        tests++;
        if (res_valid !== 1'b1 || res_product !== 16'hFE01 || res_id !== 2'd0) begin
            fails++;
            $display("FAIL max_operands: got v=%b p=%h id=%0d, need v=1 p=fe01 id=0",
                     res_valid, res_product, res_id);
        end
        step();
        #1;
        tests++;
        if (res_valid !== 1'b1 || res_product !== 16'h0000 || res_id !== 2'd1) begin
            fails++;
            $display("FAIL zero_operand: got v=%b p=%h id=%0d, need v=1 p=0000 id=1",
                     res_valid, res_product, res_id);
        end
        step();
        drain();
        $display("[TB] operand extremes checked");
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        req_valid = 4'b0010;
        req_a[15:8] = 8'($urandom);
        req_b[15:8] = 8'($urandom);
        auto_new = 1'b1;
        acc_cnt = 0;
        repeat (5) step();
        tests++;
        if (acc_cnt !== 2) begin fails++; $display("FAIL bp_accepts: got %0d, need 2", acc_cnt); end
        #1;
        tests++;
        if (req_ready !== '0) begin fails++; $display("FAIL bp_ready_low: got %b, need 0000", req_ready); end
        res_ready = 1'b1;
        repeat (4) step();
        auto_new = 1'b0;
        drain();
        $display("[TB] backpressure stall and drain checked");
    endtask

    task automatic test_flush();
        int saved_ptr;
        res_ready = 1'b0;
        req_valid = 4'b0010;
        auto_new = 1'b1;
        step();
        step();
        saved_ptr = mptr;
        tests++;
        if (res_valid !== 1'b1) begin fails++; $display("FAIL flush_setup: got v=%b, need 1", res_valid); end
        flush = 1'b1;
        #1;
        tests++;
        if (req_ready !== '0) begin fails++; $display("FAIL flush_ready: got %b, need 0000", req_ready); end
        step();
        flush = 1'b0;
        req_valid = '0;
        #1;
        tests++;
        if (res_valid !== 1'b0) begin fails++; $display("FAIL flush_clear: got v=%b, need 0", res_valid); end
        res_ready = 1'b1;
        repeat (2) step();
        req_valid = '1;
        #1;
        tests++;
        if (req_ready !== (4'b0001 << saved_ptr)) begin
            fails++;
            $display("FAIL flush_ptr_kept: got req_ready=%b, need winner %0d", req_ready, saved_ptr);
        end
        step();
        auto_new = 1'b0;
        drain();
        $display("[TB] flush checked");
    endtask

    task automatic test_reset_mid();
        req_valid = '1;
        res_ready = 1'b1;
        auto_new = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        tests++;
        if (res_valid !== 1'b0 || res_product !== 16'd0 || res_id !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got v=%b p=%h id=%0d, need v=0 p=0000 id=0",
                     res_valid, res_product, res_id);
        end
        tests++;
        if (req_ready !== '0) begin fails++; $display("FAIL midreset_ready: got %b, need 0000", req_ready); end
        sb.delete();
        mptr = 0;
        hold_chk = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin fails++; $display("FAIL midreset_ptr: got %b, need 0001", req_ready); end
        step();
        auto_new = 1'b0;
        drain();
        $display("[TB] reset mid-stream checked");
    endtask

`ifdef MULT_RR_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        mptr = 0;
        hold_chk = 1'b0;
        tests++;
        if (op_count !== 16'd0) begin fails++; $display("FAIL perf_reset: got %0d, need 0", op_count); end
        req_valid = '1;
        res_ready = 1'b1;
        auto_new = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 30 && acc_cnt < 10; i++) step();
        auto_new = 1'b0;
        drain();
        tests++;
        if (op_count !== 16'd10) begin fails++; $display("FAIL perf_count: got %0d, need 10", op_count); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        tests++;
        if (op_count !== 16'd10) begin fails++; $display("FAIL perf_flush: got %0d, need 10", op_count); end
        $display("[TB] op_count checked");
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100us, need finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_max();
        test_backpressure();
        test_flush();
        test_reset_mid();
`ifdef MULT_RR_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
